// File: rtl/async_fsmc_master.sv
// -----------------------------------------------------------------------------
// async_fsmc_master
//
// Single-clock master for an FSMC-style multiplexed address/data SRAM bus.
// Each accepted command runs IDLE -> ADDR (ADDSET cycles) -> DATA (DATAST
// cycles) -> HOLD (1 cycle) -> TURN (BUSTURN cycles, skipped when 0) -> IDLE.
// Every output is a flop, so the bus pins never see a combinational path
// from any input.
//
// Handshake: a command transfers on a rising aclk edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only while idle, and all command
// fields are sampled on that same edge. cmd_valid is ignored otherwise.
//
// Ports
//   aclk, areset          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_write             1 = write, 0 = read
//   cmd_addr, cmd_wdata   word address and write data
//   cmd_be                byte enables, active-high (bit1 = [15:8])
//   done                  one-cycle pulse in HOLD
//   rd_data               read data, updated when a read completes
//   fsmc_nex/nwe/noe      chip select / write strobe / output enable (low)
//   fsmc_nbl              byte lanes, active-low
//   fsmc_da_i/o/t         multiplexed bus in / out / tristate (1 = input)
//   state_dbg             current FSM state, for observation
// -----------------------------------------------------------------------------
module async_fsmc_master #(
    parameter int ADDSET    = 2,
    parameter int DATAST    = 3,
    parameter int BUSTURN   = 1,
    parameter int SIM_DELAY = 0
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    input  logic [1:0]  cmd_be,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        fsmc_nex,
    output logic        fsmc_nwe,
    output logic        fsmc_noe,
    output logic [1:0]  fsmc_nbl,
    input  logic [15:0] fsmc_da_i,
    output logic [15:0] fsmc_da_o,
    output logic [15:0] fsmc_da_t,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_TURN = 3'd4;

    // Reload values: the counter runs length-1 down to 0 in each state.
    localparam logic [7:0] ADDR_LD = 8'(ADDSET - 1);
    localparam logic [7:0] DATA_LD = 8'(DATAST - 1);
    localparam logic [7:0] TURN_LD = 8'(BUSTURN - 1);

    // Registers always update with zero delay; SIM_DELAY only takes part in
    // the elaboration-time range check so existing instantiations still bind.
    if (ADDSET < 1 || ADDSET > 15 || DATAST < 1 || DATAST > 255 ||
        BUSTURN < 0 || BUSTURN > 15 || SIM_DELAY < 0) begin : g_param_check
        $error("async_fsmc_master: parameter out of legal range");
    end

    logic [2:0]  state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        wr_q;
    logic [15:0] wdata_q;
    logic        handshake;

    assign handshake = cmd_valid && cmd_ready;
    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (handshake) begin
                    state_nxt = S_ADDR;
                    cnt_nxt   = ADDR_LD;
                end
            end
            S_ADDR: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_DATA;
                    cnt_nxt   = DATA_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_DATA: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_HOLD: begin
                if (BUSTURN == 0) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 8'd0;
                end else begin
                    state_nxt = S_TURN;
                    cnt_nxt   = TURN_LD;
                end
            end
            S_TURN: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Outputs are registered from the next state, so pin values line up
    // exactly with the state the FSM occupies during each cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            wr_q      <= 1'b0;
            wdata_q   <= 16'h0000;
            cmd_ready <= 1'b0;
            done      <= 1'b0;
            rd_data   <= 16'h0000;
            fsmc_nex  <= 1'b1;
            fsmc_nwe  <= 1'b1;
            fsmc_noe  <= 1'b1;
            fsmc_nbl  <= 2'b11;
            fsmc_da_o <= 16'h0000;
            fsmc_da_t <= 16'hFFFF;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cmd_ready <= (state_nxt == S_IDLE);
            done      <= (state_nxt == S_HOLD);

            if (handshake) begin
                wr_q      <= cmd_write;
                wdata_q   <= cmd_wdata;
                fsmc_nbl  <= ~cmd_be;
                fsmc_da_o <= cmd_addr;
            end else if (state_nxt == S_TURN || state_nxt == S_IDLE) begin
                fsmc_nbl <= 2'b11;
            end

            // Read data is taken on the edge that leaves the last DATA cycle.
            if (state == S_DATA && state_nxt == S_HOLD && !wr_q) begin
                rd_data <= fsmc_da_i;
            end

            case (state_nxt)
                S_ADDR: begin
                    fsmc_nex  <= 1'b0;
                    fsmc_nwe  <= 1'b1;
                    fsmc_noe  <= 1'b1;
                    fsmc_da_t <= 16'h0000;
                end
                S_DATA: begin
                    fsmc_nex  <= 1'b0;
                    fsmc_nwe  <= ~wr_q;
                    fsmc_noe  <= wr_q;
                    fsmc_da_t <= wr_q ? 16'h0000 : 16'hFFFF;
                    if (wr_q) begin
                        fsmc_da_o <= wdata_q;
                    end
                end
                S_HOLD: begin
                    // Bus direction and data are left as in DATA.
                    fsmc_nex <= 1'b0;
                    fsmc_nwe <= 1'b1;
                    fsmc_noe <= 1'b1;
                end
                default: begin
                    fsmc_nex  <= 1'b1;
                    fsmc_nwe  <= 1'b1;
                    fsmc_noe  <= 1'b1;
                    fsmc_da_t <= 16'hFFFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_async_fsmc_master.sv
// -----------------------------------------------------------------------------
// tb_async_fsmc_master
//
// Directed bench for async_fsmc_master. Instance dut_a uses the default
// timing (ADDSET=2, DATAST=3, BUSTURN=1); dut_b uses DATAST=1, BUSTURN=0.
// use_b steers the shared command stimulus and the observed signals.
// Cycle k of an access is the k-th cycle after the handshake edge, sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_async_fsmc_master;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        areset;
    logic        cmd_valid, cmd_write, use_b;
    logic [15:0] cmd_addr, cmd_wdata, bus_val;
    logic [1:0]  cmd_be;

    logic        valid_a, ready_a, done_a, nex_a, nwe_a, noe_a;
    logic [1:0]  nbl_a;
    logic [15:0] rd_a, dai_a, dao_a, dat_a;
    logic [2:0]  st_a;
    logic        valid_b, ready_b, done_b, nex_b, nwe_b, noe_b;
    logic [1:0]  nbl_b;
    logic [15:0] rd_b, dai_b, dao_b, dat_b;
    logic [2:0]  st_b;

    assign valid_a = cmd_valid && !use_b;
    assign valid_b = cmd_valid && use_b;
    // Bus model: memory drives bus_val while noe is low, garbage otherwise.
    assign dai_a = noe_a ? 16'hDEAD : bus_val;
    assign dai_b = noe_b ? 16'hDEAD : bus_val;

    async_fsmc_master #(.ADDSET(2), .DATAST(3), .BUSTURN(1), .SIM_DELAY(0)) dut_a (
        .aclk(aclk), .areset(areset), .cmd_valid(valid_a), .cmd_ready(ready_a),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_be(cmd_be), .done(done_a), .rd_data(rd_a), .fsmc_nex(nex_a),
        .fsmc_nwe(nwe_a), .fsmc_noe(noe_a), .fsmc_nbl(nbl_a), .fsmc_da_i(dai_a),
        .fsmc_da_o(dao_a), .fsmc_da_t(dat_a), .state_dbg(st_a)
    );

    async_fsmc_master #(.ADDSET(2), .DATAST(1), .BUSTURN(0), .SIM_DELAY(0)) dut_b (
        .aclk(aclk), .areset(areset), .cmd_valid(valid_b), .cmd_ready(ready_b),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_be(cmd_be), .done(done_b), .rd_data(rd_b), .fsmc_nex(nex_b),
        .fsmc_nwe(nwe_b), .fsmc_noe(noe_b), .fsmc_nbl(nbl_b), .fsmc_da_i(dai_b),
        .fsmc_da_o(dao_b), .fsmc_da_t(dat_b), .state_dbg(st_b)
    );

    logic        m_ready, m_done, m_nex, m_nwe, m_noe;
    logic [1:0]  m_nbl;
    logic [15:0] m_da_o, m_da_t, m_rd;
    assign m_ready = use_b ? ready_b : ready_a;
    assign m_done  = use_b ? done_b  : done_a;
    assign m_nex   = use_b ? nex_b   : nex_a;
    assign m_nwe   = use_b ? nwe_b   : nwe_a;
    assign m_noe   = use_b ? noe_b   : noe_a;
    assign m_nbl   = use_b ? nbl_b   : nbl_a;
    assign m_da_o  = use_b ? dao_b   : dao_a;
    assign m_da_t  = use_b ? dat_b   : dat_a;
    assign m_rd    = use_b ? rd_b    : rd_a;

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Per-access trace filled by run_cmd
    logic [15:0] tr_da_o [0:15];
    logic [15:0] tr_da_t [0:15];
    logic [1:0]  tr_nbl  [0:15];
    int          nex_low, nwe_low, noe_low, nbl01_cnt, done_cnt, done_cyc, ready_cyc;
    logic [15:0] rd_at_done;

    // ---------------- driver ----------------
    task automatic run_cmd(input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [1:0] be);
        int guard;
        @(negedge aclk);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_be    = be;
        cmd_valid = 1'b1;
        guard = 0;
        while (!m_ready && guard < 20) begin
            @(negedge aclk);
            guard++;
        end
        check_eq("handshake_wait", 32'(guard < 20), 32'd1);
        @(posedge aclk);
        nex_low = 0; nwe_low = 0; noe_low = 0; nbl01_cnt = 0;
        done_cnt = 0; done_cyc = -1; ready_cyc = -1; rd_at_done = 16'h0000;
        for (int k = 1; k < 16; k++) begin
            @(negedge aclk);
            if (k == 1) cmd_valid = 1'b0;
            tr_da_o[k] = m_da_o;
            tr_da_t[k] = m_da_t;
            tr_nbl[k]  = m_nbl;
            if (!m_nex) nex_low++;
            if (!m_nwe) nwe_low++;
            if (!m_noe) noe_low++;
            if (m_nbl == 2'b01) nbl01_cnt++;
            if (m_done) begin
                done_cnt++;
                done_cyc   = k;
                rd_at_done = m_rd;
            end
            if (m_ready) begin
                ready_cyc = k;
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    int   hs, dn, falls;
    int   hs_t [0:3];
    logic prev_nex;

    initial begin
        areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; use_b = 1'b0;
        cmd_addr = 16'h0000; cmd_wdata = 16'h0000; cmd_be = 2'b11; bus_val = 16'h1234;
        repeat (3) @(negedge aclk);

        // Reset state
        check_eq("rst_ready", ready_a, 1'b0);
        check_eq("rst_done", done_a, 1'b0);
        check_eq("rst_nex", nex_a, 1'b1);
        check_eq("rst_nwe_noe", {nwe_a, noe_a}, 2'b11);
        check_eq("rst_nbl", nbl_a, 2'b11);
        check_eq("rst_da_t", dat_a, 16'hFFFF);
        check_eq("rst_da_o", dao_a, 16'h0000);
        check_eq("rst_rd_data", rd_a, 16'h0000);
        areset = 1'b0;
        @(negedge aclk);
        check_eq("ready_after_rst", ready_a, 1'b1);

        // Basic write
        run_cmd(1'b1, 16'h0012, 16'hA55A, 2'b11);
        check_eq("wr_nex_low", nex_low, 6);
        check_eq("wr_da_o_addr_c1", tr_da_o[1], 16'h0012);
        check_eq("wr_da_o_addr_c2", tr_da_o[2], 16'h0012);
        check_eq("wr_da_o_data_c3", tr_da_o[3], 16'hA55A);
        check_eq("wr_da_o_data_c6", tr_da_o[6], 16'hA55A);
        check_eq("wr_da_t_c1", tr_da_t[1], 16'h0000);
        check_eq("wr_da_t_hold", tr_da_t[6], 16'h0000);
        check_eq("wr_da_t_turn", tr_da_t[7], 16'hFFFF);
        check_eq("wr_nwe_low", nwe_low, 3);
        check_eq("wr_noe_low", noe_low, 0);
        check_eq("wr_done_cyc", done_cyc, 6);
        check_eq("wr_done_cnt", done_cnt, 1);
        check_eq("wr_ready_cyc", ready_cyc, 8);
        check_eq("wr_nbl_c1", tr_nbl[1], 2'b00);

        // Read with bus model
        run_cmd(1'b0, 16'h0034, 16'h0000, 2'b11);
        check_eq("rd_noe_low", noe_low, 3);
        check_eq("rd_nwe_low", nwe_low, 0);
        check_eq("rd_da_o_addr", tr_da_o[1], 16'h0034);
        check_eq("rd_da_t_c2", tr_da_t[2], 16'h0000);
        check_eq("rd_da_t_c3", tr_da_t[3], 16'hFFFF);
        check_eq("rd_da_t_hold", tr_da_t[6], 16'hFFFF);
        check_eq("rd_data_at_done", rd_at_done, 16'h1234);
        check_eq("rd_done_cyc", done_cyc, 6);

        // Partial byte enable; rd_data must survive a write
        run_cmd(1'b1, 16'h0056, 16'hBEEF, 2'b10);
        check_eq("be10_nbl01_cycles", nbl01_cnt, 6);
        check_eq("be10_nbl_turn", tr_nbl[7], 2'b11);
        check_eq("be10_nbl_idle", tr_nbl[8], 2'b11);
        check_eq("rd_data_held", m_rd, 16'h1234);

        // No byte enables: full timing, lanes all high
        run_cmd(1'b1, 16'h0078, 16'h0F0F, 2'b00);
        check_eq("be00_nbl_c1", tr_nbl[1], 2'b11);
        check_eq("be00_nex_low", nex_low, 6);
        check_eq("be00_ready_cyc", ready_cyc, 8);

        // cmd_valid held for three back-to-back commands
        @(negedge aclk);
        cmd_write = 1'b1; cmd_addr = 16'h0100; cmd_wdata = 16'h5A5A; cmd_be = 2'b11;
        cmd_valid = 1'b1;
        hs = 0; dn = 0; falls = 0; prev_nex = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (cmd_valid && m_ready) begin
                if (hs < 4) hs_t[hs] = c;
                hs++;
            end
            if (m_done) dn++;
            if (prev_nex && !m_nex) falls++;
            prev_nex = m_nex;
            @(negedge aclk);
            if (hs == 3) cmd_valid = 1'b0;
        end
        check_eq("b2b_handshakes", hs, 3);
        check_eq("b2b_done_pulses", dn, 3);
        check_eq("b2b_nex_falls", falls, 3);
        check_eq("b2b_spacing_1", hs_t[1] - hs_t[0], 8);
        check_eq("b2b_spacing_2", hs_t[2] - hs_t[1], 8);

        // Reset pulsed during DATA of a write
        @(negedge aclk);
        cmd_write = 1'b1; cmd_addr = 16'h0200; cmd_wdata = 16'h1111; cmd_be = 2'b11;
        cmd_valid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge aclk);
        check_eq("abort_pre_nwe", nwe_a, 1'b0);
        areset = 1'b1;
        #1;
        check_eq("abort_nwe", nwe_a, 1'b1);
        check_eq("abort_nex", nex_a, 1'b1);
        check_eq("abort_da_t", dat_a, 16'hFFFF);
        dn = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            if (done_a) dn++;
        end
        areset = 1'b0;
        @(negedge aclk);
        if (done_a) dn++;
        check_eq("abort_no_done", dn, 0);
        check_eq("abort_ready_rise", ready_a, 1'b1);
        run_cmd(1'b1, 16'h0300, 16'h2222, 2'b11);
        check_eq("post_abort_done_cyc", done_cyc, 6);
        check_eq("post_abort_ready_cyc", ready_cyc, 8);

        // DATAST=1, BUSTURN=0 instance
        use_b = 1'b1;
        run_cmd(1'b1, 16'h0012, 16'hA55A, 2'b11);
        check_eq("short_nex_low", nex_low, 4);
        check_eq("short_nwe_low", nwe_low, 1);
        check_eq("short_da_o_addr", tr_da_o[2], 16'h0012);
        check_eq("short_da_o_data", tr_da_o[3], 16'hA55A);
        check_eq("short_done_cyc", done_cyc, 4);
        check_eq("short_ready_cyc", ready_cyc, 5);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
